// File: rtl/dispatch_1x4_32bit_pkg.sv
// Shared types and constants for the 1-to-4 word dispatcher and its per-channel slots.
package dispatch_1x4_32bit_pkg;

  localparam int DATA_W = 32;
  localparam int NCH    = 4;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/dispatch_1x4_32bit_slot.sv
// One channel of the dispatcher: one-entry word buffer, valid flag and accept counter.
module dispatch_slot
  import dispatch_1x4_32bit_pkg::*;
#(
  parameter int DATA_W = dispatch_1x4_32bit_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ready_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Load wins over pop so a same-cycle pop+accept keeps the slot FULL with no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      state_d = FULL;
      data_d  = load_data_i;
      cnt_d   = cnt_q + CNT_ONE;
    end else if (state_q == FULL && pop_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = (state_q == FULL);
  assign ready_o = (state_q == EMPTY) || pop_ready_i;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dispatch_1x4_32bit.sv
// Registered 1-to-4 word dispatcher: steers one producer word into one of four buffered channels.
// Optional broadcast (load all four channels at once) is enabled by defining DISPATCH_BCAST_EN.
module dispatch_1x4_32bit
  import dispatch_1x4_32bit_pkg::*;
#(
  parameter int DATA_W = dispatch_1x4_32bit_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DISPATCH_BCAST_EN
  input  logic              in_bcast,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic              out_valid3,
  input  logic              out_ready0,
  input  logic              out_ready1,
  input  logic              out_ready2,
  input  logic              out_ready3,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
);

  logic [NCH-1:0]             load, slot_rdy, slot_vld, pop_rdy;
  logic [NCH-1:0][DATA_W-1:0] slot_data;
  logic [NCH-1:0][CNT_W-1:0]  slot_cnt;
  ch_sel_t                    sel;
  logic                       sel_ready, bcast, accept;

  assign sel       = in_sel;
  assign pop_rdy   = {out_ready3, out_ready2, out_ready1, out_ready0};
  assign sel_ready = slot_rdy[sel];

`ifdef DISPATCH_BCAST_EN
  assign bcast    = in_bcast;
  assign in_ready = in_bcast ? (&slot_rdy) : sel_ready;
`else
  assign bcast    = 1'b0;
  assign in_ready = sel_ready;
`endif

  // in_ready is deliberately independent of in_valid; out_ready feeds it combinationally.
  assign accept = in_valid && in_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    assign load[g] = accept && (bcast || (sel == ch_sel_t'(g)));

    dispatch_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load[g]),
      .load_data_i (in_data),
      .pop_ready_i (pop_rdy[g]),
      .data_o      (slot_data[g]),
      .valid_o     (slot_vld[g]),
      .cnt_o       (slot_cnt[g]),
      .ready_o     (slot_rdy[g])
    );
  end

  assign {out_valid3, out_valid2, out_valid1, out_valid0} = slot_vld;
  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign cnt0      = slot_cnt[0];
  assign cnt1      = slot_cnt[1];
  assign cnt2      = slot_cnt[2];
  assign cnt3      = slot_cnt[3];

endmodule
